eeprom_txn_sequencer: RTL and testbench

- Sequences single-byte EEPROM read and write transactions onto the byte-level I2C master.
- Sits between the application FSM and the I2C master, which drives `i2c_pin_primitives_ice40`.
- Expands each request into START / address / data / STOP commands and handles NACKs.
- After a write, ACK-polls the device until its internal write cycle completes, then returns one response per request.

---
 rtl/eeprom_txn_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_eeprom_txn_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eeprom_txn_sequencer.sv
// Single-byte EEPROM read/write sequencer: expands each request into byte-level
// I2C master commands, recovers from NACKs and ACK-polls after writes.
module eeprom_txn_sequencer #(
    parameter logic [6:0] DEV_ADDR   = 7'h50,
    parameter int         ADDR_BYTES = 2,
    parameter int         POLL_MAX   = 255
) (
    input  logic        ICE_CLK,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        m_cmd_valid,
    input  logic        m_cmd_ready,
    output logic [2:0]  m_cmd,
    output logic [7:0]  m_wdata,
    input  logic        m_done,
    input  logic        m_nack,
    input  logic [7:0]  m_rdata
);

    localparam logic [2:0] CMD_START     = 3'd0;
    localparam logic [2:0] CMD_STOP      = 3'd1;
    localparam logic [2:0] CMD_WRITE     = 3'd2;
    localparam logic [2:0] CMD_READ_NACK = 3'd4;
    localparam logic [7:0] POLL_LIMIT    = 8'(POLL_MAX);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [3:0] {
        STEP_START, STEP_DEVW, STEP_AHI, STEP_ALO, STEP_DATA, STEP_STOP,
        STEP_RSTART, STEP_DEVR, STEP_RDNACK, STEP_PSTART, STEP_PDEV, STEP_PSTOP
    } step_t;

    // With a one-byte address the high address byte is never sent.
    localparam step_t FIRST_ADDR_STEP = (ADDR_BYTES == 1) ? STEP_ALO : STEP_AHI;

    state_t      state_r;
    step_t       step_r;
    logic        write_r;
    logic [15:0] addr_r;
    logic [7:0]  wdata_r;
    logic        err_r;
    logic        poll_done_r;
    logic [7:0]  poll_cnt_r;
    logic [7:0]  rd_byte_r;
    logic        req_ready_r;
    logic        busy_r;
    logic        resp_valid_r;
    logic        resp_err_r;
    logic [7:0]  resp_rdata_r;
    logic        m_cmd_valid_r;
    logic [2:0]  m_cmd_r;
    logic [7:0]  m_wdata_r;

    step_t       next_step_s;
    logic        finish_s;
    logic        set_err_s;
    logic        poll_done_s;
    logic [7:0]  poll_cnt_s;

    function automatic logic [2:0] step_cmd(input step_t s);
        case (s)
            STEP_START, STEP_RSTART, STEP_PSTART: step_cmd = CMD_START;
            STEP_STOP, STEP_PSTOP:                step_cmd = CMD_STOP;
            STEP_RDNACK:                          step_cmd = CMD_READ_NACK;
            default:                              step_cmd = CMD_WRITE;
        endcase
    endfunction

    function automatic logic [7:0] step_byte(input step_t s, input logic [15:0] a,
                                             input logic [7:0] d);
        case (s)
            STEP_DEVW, STEP_PDEV: step_byte = {DEV_ADDR, 1'b0};
            STEP_DEVR:            step_byte = {DEV_ADDR, 1'b1};
            STEP_AHI:             step_byte = a[15:8];
            STEP_ALO:             step_byte = a[7:0];
            STEP_DATA:            step_byte = d;
            default:              step_byte = 8'h00;
        endcase
    endfunction

    // Successor step for the command that just completed, given its NACK status.
    always_comb begin
        next_step_s = STEP_STOP;
        finish_s    = 1'b0;
        set_err_s   = 1'b0;
        poll_done_s = poll_done_r;
        poll_cnt_s  = poll_cnt_r;
        case (step_r)
            STEP_START:  next_step_s = STEP_DEVW;
            STEP_DEVW: begin
                if (m_nack) begin
                    set_err_s = 1'b1;
                end else begin
                    next_step_s = FIRST_ADDR_STEP;
                end
            end
            STEP_AHI: begin
                if (m_nack) begin
                    set_err_s = 1'b1;
                end else begin
                    next_step_s = STEP_ALO;
                end
            end
            STEP_ALO: begin
                if (m_nack) begin
                    set_err_s = 1'b1;
                end else if (write_r) begin
                    next_step_s = STEP_DATA;
                end else begin
                    next_step_s = STEP_RSTART;
                end
            end
            STEP_DATA: begin
                if (m_nack) begin
                    set_err_s = 1'b1;
                end else begin
                    set_err_s = 1'b0;
                end
            end
            // A clean write STOP starts the poll loop; any other STOP ends the request.
            STEP_STOP: begin
                if (write_r && !err_r) begin
                    next_step_s = STEP_PSTART;
                end else begin
                    finish_s = 1'b1;
                end
            end
            STEP_RSTART: next_step_s = STEP_DEVR;
            STEP_DEVR: begin
                if (m_nack) begin
                    set_err_s = 1'b1;
                end else begin
                    next_step_s = STEP_RDNACK;
                end
            end
            STEP_RDNACK: next_step_s = STEP_STOP;
            STEP_PSTART: next_step_s = STEP_PDEV;
            STEP_PDEV: begin
                next_step_s = STEP_PSTOP;
                if (m_nack) begin
                    poll_cnt_s = poll_cnt_r + 8'd1;
                    if (poll_cnt_s == POLL_LIMIT) begin
                        poll_done_s = 1'b1;
                        set_err_s   = 1'b1;
                    end else begin
                        poll_done_s = 1'b0;
                    end
                end else begin
                    poll_done_s = 1'b1;
                end
            end
            STEP_PSTOP: begin
                if (poll_done_r) begin
                    finish_s = 1'b1;
                end else begin
                    next_step_s = STEP_PSTART;
                end
            end
            default: finish_s = 1'b1;
        endcase
    end

    // Transaction FSM with all outputs registered.
    always_ff @(posedge ICE_CLK) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            step_r        <= STEP_START;
            write_r       <= 1'b0;
            addr_r        <= 16'h0000;
            wdata_r       <= 8'h00;
            err_r         <= 1'b0;
            poll_done_r   <= 1'b0;
            poll_cnt_r    <= 8'h00;
            rd_byte_r     <= 8'h00;
            req_ready_r   <= 1'b1;
            busy_r        <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_err_r    <= 1'b0;
            resp_rdata_r  <= 8'h00;
            m_cmd_valid_r <= 1'b0;
            m_cmd_r       <= 3'd0;
            m_wdata_r     <= 8'h00;
        end else begin
            resp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        write_r       <= req_write;
                        addr_r        <= req_addr;
                        wdata_r       <= req_wdata;
                        err_r         <= 1'b0;
                        poll_done_r   <= 1'b0;
                        poll_cnt_r    <= 8'h00;
                        step_r        <= STEP_START;
                        m_cmd_valid_r <= 1'b1;
                        m_cmd_r       <= CMD_START;
                        m_wdata_r     <= 8'h00;
                        req_ready_r   <= 1'b0;
                        busy_r        <= 1'b1;
                        state_r       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (m_cmd_ready) begin
                        m_cmd_valid_r <= 1'b0;
                        state_r       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_done) begin
                        err_r       <= err_r | set_err_s;
                        poll_cnt_r  <= poll_cnt_s;
                        poll_done_r <= poll_done_s;
                        if (step_r == STEP_RDNACK) begin
                            rd_byte_r <= m_rdata;
                        end
                        if (finish_s) begin
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= err_r;
                            if (!write_r && !err_r) begin
                                resp_rdata_r <= rd_byte_r;
                            end
                            state_r <= ST_RESP;
                        end else begin
                            step_r        <= next_step_s;
                            m_cmd_valid_r <= 1'b1;
                            m_cmd_r       <= step_cmd(next_step_s);
                            m_wdata_r     <= step_byte(next_step_s, addr_r, wdata_r);
                            state_r       <= ST_SEND;
                        end
                    end
                end
                ST_RESP: begin
                    req_ready_r <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign req_ready   = req_ready_r;
    assign busy        = busy_r;
    assign resp_valid  = resp_valid_r;
    assign resp_err    = resp_err_r;
    assign resp_rdata  = resp_rdata_r;
    assign m_cmd_valid = m_cmd_valid_r;
    assign m_cmd       = m_cmd_r;
    assign m_wdata     = m_wdata_r;

endmodule

// File: tb/tb_eeprom_txn_sequencer.sv
// Scoreboard bench: a transcript model predicts every master command and the
// response of each request; a master model and a response monitor consume them.
module tb_eeprom_txn_sequencer;

    localparam int POLL_MAX = 3;
    localparam logic [2:0] C_START = 3'd0, C_STOP = 3'd1, C_WRITE = 3'd2, C_RNACK = 3'd4;

    logic        ICE_CLK = 1'b0;
    logic        rst, req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata, resp_rdata, m_wdata, m_rdata;
    logic        resp_valid, resp_err, busy, m_cmd_valid, m_cmd_ready, m_done, m_nack;
    logic [2:0]  m_cmd;

    eeprom_txn_sequencer #(.POLL_MAX(POLL_MAX)) dut (
        .ICE_CLK(ICE_CLK), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd(m_cmd), .m_wdata(m_wdata),
        .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
    );

    always #5 ICE_CLK = ~ICE_CLK;

    typedef struct packed {
        logic [2:0] cmd;
        logic [7:0] wd;
        logic       nack;
        logic [7:0] rd;
        logic       last;
    } cmd_t;
    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } resp_t;

    cmd_t  exp_cmd[$];
    resp_t exp_resp[$];
    int    n_checks = 0, n_errors = 0;
    logic [7:0] last_rdata = 8'h00;
    int    mst_st = 0, acc_total = 0, hold_at = -1;
    bit    mst_abort = 1'b0, long_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void pc(input logic [2:0] c, input logic [7:0] wd, input logic nk,
                               input logic [7:0] rd, input logic last);
        cmd_t e;
        e.cmd = c; e.wd = wd; e.nack = nk; e.rd = rd; e.last = last;
        exp_cmd.push_back(e);
    endfunction

    // Reference transcript: nack_at 1..4 names the WRITE byte that is refused
    // (device, addr hi, addr lo, data/device-read); pn = PDEV NACKs before an ACK.
    function automatic void model_req(input bit w, input logic [15:0] a, input logic [7:0] wd,
                                      input int nack_at, input int pn, input logic [7:0] rd);
        logic [7:0] bytes_v [4];
        resp_t r;
        bit failed;
        failed = 1'b0;
        bytes_v[0] = 8'hA0; bytes_v[1] = a[15:8]; bytes_v[2] = a[7:0]; bytes_v[3] = wd;
        r.err = 1'b0;
        r.rdata = last_rdata;
        pc(C_START, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < (w ? 4 : 3) && !failed; i++) begin
            pc(C_WRITE, bytes_v[i], nack_at == i + 1, 8'h00, 1'b0);
            if (nack_at == i + 1) failed = 1'b1;
        end
        if (failed) begin
            pc(C_STOP, 8'h00, 1'b0, 8'h00, 1'b1);
            r.err = 1'b1;
        end else if (w) begin
            pc(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
            for (int k = 0; k < 256; k++) begin
                pc(C_START, 8'h00, 1'b0, 8'h00, 1'b0);
                pc(C_WRITE, 8'hA0, k < pn, 8'h00, 1'b0);
                if (k >= pn) begin
                    pc(C_STOP, 8'h00, 1'b0, 8'h00, 1'b1);
                    r.err = 1'b0;
                    break;
                end else if (k + 1 == POLL_MAX) begin
                    pc(C_STOP, 8'h00, 1'b0, 8'h00, 1'b1);
                    r.err = 1'b1;
                    break;
                end else begin
                    pc(C_STOP, 8'h00, 1'b0, 8'h00, 1'b0);
                end
            end
        end else begin
            pc(C_START, 8'h00, 1'b0, 8'h00, 1'b0);
            pc(C_WRITE, 8'hA1, nack_at == 4, 8'h00, 1'b0);
            if (nack_at == 4) begin
                pc(C_STOP, 8'h00, 1'b0, 8'h00, 1'b1);
                r.err = 1'b1;
            end else begin
                pc(C_RNACK, 8'h00, 1'b0, rd, 1'b0);
                pc(C_STOP, 8'h00, 1'b0, 8'h00, 1'b1);
                last_rdata = rd;
                r.rdata = rd;
            end
        end
        exp_resp.push_back(r);
    endfunction

    // Byte-level master model: random ready/done latency, spurious done while stalled.
    initial begin : master
        cmd_t cur;
        logic [2:0] cap_cmd;
        logic [7:0] cap_wd;
        int stall, dly, post;
        bit post_last;
        post = 0; post_last = 1'b0; stall = 0; dly = 0;
        cap_cmd = 3'd0; cap_wd = 8'h00; cur = '0;
        m_cmd_ready = 1'b0; m_done = 1'b0; m_nack = 1'b0; m_rdata = 8'h00;
        forever begin
            @(negedge ICE_CLK);
            m_done  = 1'b0;
            m_nack  = 1'($urandom);
            m_rdata = 8'($urandom);
            if (rst || mst_abort) begin
                mst_abort = 1'b0; mst_st = 0; m_cmd_ready = 1'b0; post = 0;
            end else begin
                if (post == 1) begin
                    if (post_last) begin
                        chk("resp_valid_after_final_stop", resp_valid, 1);
                        chk("no_cmd_after_final_stop", m_cmd_valid, 0);
                        post = 2;
                    end else begin
                        chk("next_cmd_after_done", m_cmd_valid, 1);
                        post = 0;
                    end
                end else if (post == 2) begin
                    chk("req_ready_after_resp", req_ready, 1);
                    chk("busy_cleared_after_resp", busy, 0);
                    post = 0;
                end
                case (mst_st)
                    0: if (m_cmd_valid) begin
                        cap_cmd = m_cmd; cap_wd = m_wdata;
                        stall = long_stall ? 10 : $urandom_range(0, 2);
                        if (stall == 0) begin m_cmd_ready = 1'b1; mst_st = 2; end
                        else mst_st = 1;
                    end
                    1: begin
                        chk("cmd_valid_held", m_cmd_valid, 1);
                        chk("cmd_stable", m_cmd, cap_cmd);
                        chk("wdata_stable", m_wdata, cap_wd);
                        if ($urandom_range(0, 3) == 0) m_done = 1'b1;
                        stall--;
                        if (stall == 0) begin m_cmd_ready = 1'b1; mst_st = 2; end
                    end
                    2: begin
                        m_cmd_ready = 1'b0;
                        acc_total++;
                        chk("cmd_valid_drops_after_handshake", m_cmd_valid, 0);
                        if (exp_cmd.size() == 0) begin
                            chk("unexpected_command", cap_cmd, 3'd7);
                            mst_st = 0;
                        end else begin
                            cur = exp_cmd.pop_front();
                            chk("cmd_code", cap_cmd, cur.cmd);
                            if (cur.cmd == C_WRITE) chk("cmd_byte", cap_wd, cur.wd);
                            if (acc_total == hold_at) mst_st = 4;
                            else begin
                                dly = $urandom_range(0, 2);
                                mst_st = (dly == 0) ? 5 : 3;
                            end
                        end
                    end
                    3: begin
                        dly--;
                        if (dly == 0) mst_st = 5;
                    end
                    4: mst_st = 4;
                    default: mst_st = 0;
                endcase
                if (mst_st == 5) begin
                    m_done = 1'b1;
                    if (cur.cmd == C_WRITE) m_nack = cur.nack;
                    else if (cur.cmd == C_START) m_nack = 1'b0;
                    if (cur.cmd == C_RNACK) m_rdata = cur.rd;
                    post = 1; post_last = cur.last; mst_st = 0;
                end
            end
        end
    end

    // Response monitor.
    initial begin : monitor
        resp_t r;
        forever begin
            @(negedge ICE_CLK);
            if (resp_valid) begin
                if (exp_resp.size() == 0) begin
                    chk("unexpected_response", resp_valid, 0);
                end else begin
                    r = exp_resp.pop_front();
                    chk("resp_err", resp_err, r.err);
                    chk("resp_rdata", resp_rdata, r.rdata);
                    chk("busy_with_resp", busy, 1);
                end
            end
        end
    end

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    endtask

    task automatic issue(input bit w, input logic [15:0] a, input logic [7:0] wd,
                         input int nack_at, input int pn, input logic [7:0] rd);
        int guard;
        guard = 0;
        while (!req_ready && guard < 100) begin @(negedge ICE_CLK); guard++; end
        model_req(w, a, wd, nack_at, pn, rd);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        @(negedge ICE_CLK);
        req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = 8'($urandom);
        chk("req_ready_low_after_accept", req_ready, 0);
        chk("busy_after_accept", busy, 1);
        chk("first_cmd_after_accept", m_cmd_valid, 1);
    endtask

    // Waits for the scoreboard to drain, offering ignored requests while busy.
    task automatic wait_done();
        int cyc;
        cyc = 0;
        while (!(req_ready && exp_resp.size() == 0 && exp_cmd.size() == 0) && cyc < 4000) begin
            if (!req_ready) begin
                req_valid = 1'($urandom); req_write = 1'($urandom);
                req_addr = 16'($urandom); req_wdata = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            @(negedge ICE_CLK);
            cyc++;
        end
        req_valid = 1'b0;
        if (cyc >= 4000) begin
            n_checks++; n_errors++;
            $display("FAIL txn_timeout: got %0d pending commands, expected 0", exp_cmd.size());
            finish_run();
        end
    endtask

    initial begin : main
        bit w;
        int na, pn, guard;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0; req_wdata = 8'h0;
        repeat (3) @(negedge ICE_CLK);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_m_cmd_valid", m_cmd_valid, 0);
        chk("rst_m_cmd", m_cmd, 0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        rst = 1'b0;

        issue(1'b1, 16'h1234, 8'hA5, 0, 2, 8'h00); wait_done();
        issue(1'b0, 16'h0042, 8'h00, 0, 0, 8'h5C); wait_done();
        issue(1'b0, 16'h0077, 8'h00, 1, 0, 8'h99); wait_done();
        issue(1'b1, 16'h0100, 8'h3C, 0, 9, 8'h00); wait_done();
        issue(1'b1, 16'h0203, 8'h44, 4, 0, 8'h00); wait_done();
        long_stall = 1'b1;
        issue(1'b1, 16'hABCD, 8'h5A, 0, 1, 8'h00); wait_done();
        issue(1'b0, 16'h8001, 8'h00, 0, 0, 8'hE7); wait_done();
        long_stall = 1'b0;

        // Reset while waiting for the address-high byte to complete.
        hold_at = acc_total + 3;
        issue(1'b1, 16'hBEEF, 8'h11, 0, 0, 8'h00);
        guard = 0;
        while (mst_st != 4 && guard < 200) begin @(negedge ICE_CLK); guard++; end
        chk("reached_ahi_wait", mst_st, 4);
        repeat (2) @(negedge ICE_CLK);
        rst = 1'b1; mst_abort = 1'b1; hold_at = -1;
        exp_cmd.delete(); exp_resp.delete(); last_rdata = 8'h00;
        @(negedge ICE_CLK);
        rst = 1'b0;
        chk("midrst_m_cmd_valid", m_cmd_valid, 0);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_resp_rdata", resp_rdata, 0);
        issue(1'b0, 16'h0042, 8'h00, 0, 0, 8'h3B); wait_done();

        for (int t = 0; t < 25; t++) begin
            w  = 1'($urandom);
            na = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            pn = $urandom_range(0, 4);
            long_stall = ($urandom_range(0, 7) == 0);
            issue(w, 16'($urandom), 8'($urandom), na, pn, 8'($urandom));
            wait_done();
        end
        long_stall = 1'b0;
        repeat (5) @(negedge ICE_CLK);
        finish_run();
    end

endmodule
